spi_master_mc: RTL and testbench

- Parametrised multi-chip-select SPI master; next generation of the fixed 16-bit, three-slave SPI link.
- Adds configurable word width and chip-select count, all four SPI modes (CPOL/CPHA), programmable SCLK divider and a start/busy/done handshake.
- Sits between a host register/control block and off-block SPI slaves; one transfer per start, full duplex.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sclk_gen.sv | 63 ++++++
 rtl/spi_master_mc.sv | 150 +++++++++++++++
 tb/tb_spi_master_mc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the multi-chip-select SPI master: FSM states and SPI mode encodings.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  // Mode encodings as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter shared by every phase, plus edge strobes and an edge count.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             xfer_i,
  input  logic             cpol_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             half_end_c,
  output logic             lead_stb_c,
  output logic             trail_stb_c,
  output logic             last_edge_c,
  output logic             sclk_o
);

  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned EDGE_W = $clog2(EDGES);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              edge_stb;

  // Counter compares for equality against the divider, so the full DIV_W range is usable
  assign half_end_c  = run_i && (cnt_q == div_i);
  assign edge_stb    = xfer_i && half_end_c;
  assign lead_stb_c  = edge_stb && !edge_q[0];
  assign trail_stb_c = edge_stb && edge_q[0];
  assign last_edge_c = edge_stb && (edge_q == EDGE_W'(EDGES - 1));
  assign sclk_o      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (!run_i || half_end_c) cnt_d = '0;
    if (!xfer_i) begin
      edge_d = '0;
      sclk_d = cpol_i;
    end else if (edge_stb) begin
      edge_d = edge_q + EDGE_W'(1);
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: one full-duplex MSB-first word per start, any CPOL/CPHA, programmable rate.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_CS   = 3,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned CS_IDX_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CS_IDX_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [DATA_W-1:0]   tx_data,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   cs_n
);

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              cs_ok_c, half_end_c, lead_stb_c, trail_stb_c, last_edge_c;

  assign cs_ok_c = (32'(cs_sel) < NUM_CS);

  // cpol_d feeds the generator so SCLK takes the new idle level in the first SETUP cycle
  spi_sclk_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_sclk_gen (
    .clk         (clk),
    .reset       (reset),
    .run_i       (state_q != IDLE),
    .xfer_i      (state_q == XFER),
    .cpol_i      (cpol_d),
    .div_i       (div_q),
    .half_end_c  (half_end_c),
    .lead_stb_c  (lead_stb_c),
    .trail_stb_c (trail_stb_c),
    .last_edge_c (last_edge_c),
    .sclk_o      (sclk)
  );

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    case (state_q)
      IDLE: begin
        if (start && cs_ok_c) begin
          state_d = SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = clk_div;
          busy_d  = 1'b1;
          rx_d    = '0;
          cs_n_d  = ~(NUM_CS'(1) << cs_sel);
          if (!cpha) begin
            mosi_d = tx_data[DATA_W-1];
            tx_d   = tx_data << 1;
          end else begin
            tx_d   = tx_data;
          end
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      SETUP: begin
        if (half_end_c) state_d = XFER;
      end
      XFER: begin
        // CPHA selects which edge drives and which samples
        if ((lead_stb_c && cpha_q) || (trail_stb_c && !cpha_q && !last_edge_c)) begin
          mosi_d = tx_q[DATA_W-1];
          tx_d   = tx_q << 1;
        end
        if ((lead_stb_c && !cpha_q) || (trail_stb_c && cpha_q)) begin
          rx_d = {rx_q[DATA_W-2:0], miso};
        end
        if (last_edge_c) state_d = HOLD;
      end
      HOLD: begin
        if (half_end_c) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_n_d    = '1;
          rx_data_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: vector table with a mode-aware SPI slave model and a result scoreboard.
module tb_spi_master_mc;
  import spi_pkg::*;

  localparam int unsigned DW = 16, NCS = 3, DIVW = 8, CSW = 2;

  logic            clk = 1'b0, reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [CSW-1:0]  cs_sel = '0;
  logic [DIVW-1:0] clk_div = '0;
  logic [DW-1:0]   tx_data = '0, rx_data;
  logic            busy, done, err, sclk, mosi, miso;
  logic [NCS-1:0]  cs_n;

  spi_master_mc #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW), .CS_IDX_W(CSW)) dut (
    .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .err(err), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // Slave model, configured by the test before each start
  logic [DW-1:0]  slave_word = '0;
  logic           s_cpol = 1'b0, s_cpha = 1'b0, loopback = 1'b0;
  logic [DW-1:0]  sl_sh = '0, sl_rx = '0;
  logic           sl_miso = 1'b0, sclk_prev = 1'b0, cs_bad = 1'b0;
  logic [NCS-1:0] cs_prev = '1, cs_seen = '1;
  int             cyc = 0, sl_edges = 0, gap_min = 0, gap_max = 0, last_edge_cyc = 0;
  logic           sl_lead;
  int             gap_w;

  assign miso    = loopback ? mosi : sl_miso;
  assign sl_lead = (sclk != s_cpol);
  assign gap_w   = cyc - last_edge_cyc;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= sclk;
    cs_prev   <= cs_n;
    if (cs_prev == '1 && cs_n != '1) begin
      sl_rx    <= '0;
      sl_edges <= 0;
      gap_min  <= 99999;
      gap_max  <= 0;
      cs_seen  <= cs_n;
      cs_bad   <= 1'b0;
      if (!s_cpha) begin
        sl_miso <= slave_word[DW-1];
        sl_sh   <= slave_word << 1;
      end else begin
        sl_sh   <= slave_word;
      end
    end else if (cs_n != '1) begin
      if (cs_n != cs_seen) cs_bad <= 1'b1;
      if (sclk != sclk_prev) begin
        sl_edges      <= sl_edges + 1;
        last_edge_cyc <= cyc;
        if (sl_edges != 0) begin
          if (gap_w < gap_min) gap_min <= gap_w;
          if (gap_w > gap_max) gap_max <= gap_w;
        end
        if (sl_lead == s_cpha) begin
          sl_miso <= sl_sh[DW-1];
          sl_sh   <= sl_sh << 1;
        end else begin
          sl_rx <= {sl_rx[DW-2:0], mosi};
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]     mode;
    logic [7:0]     div;
    logic [1:0]     cs;
    logic [15:0]    tx;
    logic [15:0]    sword;
    logic [15:0]    exp_rx;
    logic           loop;
    logic [2:0]     exp_cs_n;
  } vec_t;

  typedef struct packed {
    logic [15:0] rx;
    logic [15:0] cap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns on the posedge that accepts the start
  task automatic launch(input vec_t v);
    start      = 1'b1;
    cs_sel     = v.cs;
    cpol       = v.mode[1];
    cpha       = v.mode[0];
    clk_div    = v.div;
    tx_data    = v.tx;
    slave_word = v.sword;
    s_cpol     = v.mode[1];
    s_cpha     = v.mode[0];
    loopback   = v.loop;
    sb.push_back('{rx: v.exp_rx, cap: v.tx});
    @(posedge clk);
  endtask

  // Returns at the negedge of the done cycle so a back-to-back start can follow
  task automatic wait_done(input vec_t v, input int tag, input int inject_at);
    int   n, h, lat;
    bit   seen;
    exp_t e;
    h    = int'(v.div) + 1;
    lat  = 1 + h * (2 * DW + 2);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) check($sformatf("t%0d busy_after_start", tag), 64'(busy), 64'(1));
      if (inject_at != 0 && n == inject_at) begin
        start   = 1'b1;
        tx_data = ~v.tx;
        cs_sel  = CSW'((int'(v.cs) + 1) % NCS);
        cpol    = ~v.mode[1];
        cpha    = ~v.mode[0];
        clk_div = 8'd7;
      end
      if (done) seen = 1'b1;
    end
    check($sformatf("t%0d done_latency", tag), 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      check($sformatf("t%0d scoreboard_nonempty", tag), 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check($sformatf("t%0d rx_data", tag), 64'(rx_data), 64'(e.rx));
      check($sformatf("t%0d slave_capture", tag), 64'(sl_rx), 64'(e.cap));
    end
    check($sformatf("t%0d busy_in_done", tag), 64'(busy), 64'(0));
    check($sformatf("t%0d cs_n_released", tag), 64'(cs_n), 64'(3'b111));
    check($sformatf("t%0d sclk_idle", tag), 64'(sclk), 64'(v.mode[1]));
    check($sformatf("t%0d cs_n_during", tag), 64'(cs_seen), 64'(v.exp_cs_n));
    check($sformatf("t%0d cs_n_stable", tag), 64'(cs_bad), 64'(0));
    check($sformatf("t%0d sclk_edges", tag), 64'(sl_edges), 64'(2 * DW));
    check($sformatf("t%0d half_period_min", tag), 64'(gap_min), 64'(h));
    check($sformatf("t%0d half_period_max", tag), 64'(gap_max), 64'(h));
  endtask

  vec_t vecs[5];
  vec_t va, vb, vr;
  int   dn, lowcs;

  initial begin
    vecs[0] = '{mode: MODE0, div: 8'd0,   cs: 2'd0, tx: 16'hA5C3, sword: 16'h0000,
                exp_rx: 16'hA5C3, loop: 1'b1, exp_cs_n: 3'b110};
    vecs[1] = '{mode: MODE3, div: 8'd3,   cs: 2'd2, tx: 16'h1234, sword: 16'h3C5A,
                exp_rx: 16'h3C5A, loop: 1'b0, exp_cs_n: 3'b011};
    vecs[2] = '{mode: MODE1, div: 8'd1,   cs: 2'd1, tx: 16'h8001, sword: 16'hFFFE,
                exp_rx: 16'hFFFE, loop: 1'b0, exp_cs_n: 3'b101};
    vecs[3] = '{mode: MODE2, div: 8'd2,   cs: 2'd0, tx: 16'h8001, sword: 16'hFFFE,
                exp_rx: 16'hFFFE, loop: 1'b0, exp_cs_n: 3'b110};
    vecs[4] = '{mode: MODE0, div: 8'd255, cs: 2'd1, tx: 16'h5AA5, sword: 16'h0F0F,
                exp_rx: 16'h0F0F, loop: 1'b0, exp_cs_n: 3'b101};
    va = '{mode: MODE0, div: 8'd0, cs: 2'd0, tx: 16'h1111, sword: 16'h2222,
           exp_rx: 16'h2222, loop: 1'b0, exp_cs_n: 3'b110};
    vb = '{mode: MODE0, div: 8'd1, cs: 2'd1, tx: 16'h0F0F, sword: 16'h00FF,
           exp_rx: 16'h00FF, loop: 1'b0, exp_cs_n: 3'b101};
    vr = '{mode: MODE1, div: 8'd0, cs: 2'd0, tx: 16'hC0DE, sword: 16'h6E2B,
           exp_rx: 16'h6E2B, loop: 1'b0, exp_cs_n: 3'b110};

    repeat (3) @(negedge clk);
    check("reset rx_data", 64'(rx_data), 64'(0));
    check("reset busy",    64'(busy),    64'(0));
    check("reset done",    64'(done),    64'(0));
    check("reset err",     64'(err),     64'(0));
    check("reset sclk",    64'(sclk),    64'(0));
    check("reset mosi",    64'(mosi),    64'(0));
    check("reset cs_n",    64'(cs_n),    64'(3'b111));
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      launch(vecs[i]);
      wait_done(vecs[i], i, 0);
    end

    // Out-of-range chip select
    @(negedge clk);
    start = 1'b1; cs_sel = 2'd3; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("err pulse",      64'(err),  64'(1));
    check("err busy",       64'(busy), 64'(0));
    check("err cs_n",       64'(cs_n), 64'(3'b111));
    @(negedge clk);
    check("err one_cycle",  64'(err),  64'(0));
    dn = 0; lowcs = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
      if (cs_n != '1) lowcs++;
    end
    check("err no_done",    64'(dn),    64'(0));
    check("err no_cs",      64'(lowcs), 64'(0));

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    launch(va);
    wait_done(va, 10, 10);
    launch(vb);
    wait_done(vb, 11, 0);

    // Synchronous reset mid-transfer
    @(negedge clk);
    launch(vr);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset cs_n",    64'(cs_n),    64'(3'b111));
    check("midreset sclk",    64'(sclk),    64'(0));
    check("midreset busy",    64'(busy),    64'(0));
    check("midreset rx_data", 64'(rx_data), 64'(0));
    check("midreset done",    64'(done),    64'(0));
    reset = 1'b0;
    sb.delete();
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midreset no_done", 64'(dn), 64'(0));
    launch(vr);
    wait_done(vr, 20, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
